// File: rtl/dm_cache_fsm_pkg.sv
// Shared types for the direct-mapped write-back cache: CPU/memory bus records,
// tag/data array entries and the miss-handling state encoding.
package dm_cache_fsm_pkg;

   localparam int TAGMSB    = 31;
   localparam int TAGLSB    = 14;
   localparam int INDEX_MSB = 13;
   localparam int INDEX_LSB = 4;
   localparam int WORD_MSB  = 3;
   localparam int WORD_LSB  = 2;
   localparam int LINES     = 1024;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAGMSB:TAGLSB] tag;
   } cache_tag_type;

   typedef struct packed {
      logic [INDEX_MSB-INDEX_LSB:0] index;
      logic                         we;
   } cache_req_type;

   typedef logic [127:0] cache_data_type;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      logic        valid;
   } cpu_req_type;

   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cpu_result_type;

   typedef struct packed {
      logic [31:0]    addr;
      cache_data_type data;
      logic           rw;
      logic           valid;
   } mem_req_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_data_type;

   // Captured CPU request; the byte offset is never needed once accepted.
   typedef struct packed {
      logic [31:WORD_LSB] addr;
      logic [31:0]        data;
      logic               rw;
   } cache_hold_type;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE_TAG,
      ALLOCATE,
      WRITE_BACK
   } cache_state_type;

   function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] w);
      return line[{w, 5'b0} +: 32];
   endfunction

   function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] w,
                                               input logic [31:0] d);
      cache_data_type l;
      l = line;
      l[{w, 5'b0} +: 32] = d;
      return l;
   endfunction

endpackage

// File: rtl/dm_cache_fsm_if.sv
// CPU-side and memory-side bus bundle of the cache controller.
// The slave modport is the cache; the master modport is the CPU/memory environment.
interface dm_cache_fsm_if;
   import dm_cache_fsm_pkg::*;

   cpu_req_type    cpu_req;
   cpu_result_type cpu_res;
   mem_req_type    mem_req;
   mem_data_type   mem_data;

   modport master (
      output cpu_req,
      output mem_data,
      input  cpu_res,
      input  mem_req
   );

   modport slave (
      input  cpu_req,
      input  mem_data,
      output cpu_res,
      output mem_req
   );

endinterface

// File: rtl/dm_cache_fsm_arrays.sv
// Tag and data storage: synchronous write, combinational read at the same index.
// Only the tag array is cleared by reset; line data is meaningless until allocated.
module dm_cache_tag
   import dm_cache_fsm_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  cache_req_type req_i,
   input  cache_tag_type tag_wdat_i,
   output cache_tag_type tag_rdat_o
);

   cache_tag_type tags_q [LINES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LINES; i++) begin
            tags_q[i] <= '0;
         end
      end else if (req_i.we) begin
         tags_q[req_i.index] <= tag_wdat_i;
      end
   end

   assign tag_rdat_o = tags_q[req_i.index];

endmodule

module dm_cache_data
   import dm_cache_fsm_pkg::*;
(
   input  logic           clk,
   input  cache_req_type  req_i,
   input  cache_data_type data_wdat_i,
   output cache_data_type data_rdat_o
);

   cache_data_type lines_q [LINES];

   always_ff @(posedge clk) begin
      if (req_i.we) begin
         lines_q[req_i.index] <= data_wdat_i;
      end
   end

   assign data_rdat_o = lines_q[req_i.index];

endmodule

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back/write-allocate cache controller; hit answers one cycle after accept.
// Misses hold the CPU (no ready) while mem_req waits for mem_data.ready; back-to-back requests see one IDLE bubble.
module dm_cache_fsm
   import dm_cache_fsm_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   dm_cache_fsm_if.slave bus
);

   cache_state_type state_q, state_d;
   cache_hold_type  req_q, req_d;
   mem_req_type     mem_req_q, mem_req_d;
   mem_req_type     alloc_req;
   cpu_result_type  cpu_res;

   cache_req_type   tag_req, data_req;
   cache_tag_type   tag_rd, tag_wr;
   cache_data_type  data_rd, data_wr;

   logic [INDEX_MSB-INDEX_LSB:0] idx;
   logic [1:0]                   word;
   logic [TAGMSB:TAGLSB]         req_tag;
   logic                         hit;

   assign idx     = req_q.addr[INDEX_MSB:INDEX_LSB];
   assign word    = req_q.addr[WORD_MSB:WORD_LSB];
   assign req_tag = req_q.addr[TAGMSB:TAGLSB];
   assign hit     = tag_rd.valid && (tag_rd.tag == req_tag);

   assign alloc_req = '{addr: {req_q.addr[TAGMSB:INDEX_LSB], 4'h0}, data: '0, rw: 1'b0, valid: 1'b1};

   dm_cache_tag u_tag (
      .clk        (clk),
      .rst        (rst),
      .req_i      (tag_req),
      .tag_wdat_i (tag_wr),
      .tag_rdat_o (tag_rd)
   );

   dm_cache_data u_data (
      .clk         (clk),
      .req_i       (data_req),
      .data_wdat_i (data_wr),
      .data_rdat_o (data_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         req_q     <= '0;
         mem_req_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         mem_req_q <= mem_req_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      mem_req_d = mem_req_q;
      cpu_res   = '0;
      tag_req   = '{index: idx, we: 1'b0};
      data_req  = '{index: idx, we: 1'b0};
      tag_wr    = tag_rd;
      data_wr   = data_rd;

      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req.valid) begin
               req_d   = '{addr: bus.cpu_req.addr[31:WORD_LSB], data: bus.cpu_req.data,
                           rw: bus.cpu_req.rw};
               state_d = COMPARE_TAG;
            end
         end
         COMPARE_TAG: begin
            if (hit) begin
               cpu_res.ready = 1'b1;
               cpu_res.data  = get_word(data_rd, word);
               if (req_q.rw) begin
                  tag_wr.dirty = 1'b1;
                  tag_req.we   = 1'b1;
                  data_wr      = put_word(data_rd, word, req_q.data);
                  data_req.we  = 1'b1;
               end
               state_d = IDLE;
            end else if (tag_rd.valid && tag_rd.dirty) begin
               // Victim must reach memory before its slot can be refilled.
               mem_req_d = '{addr: {tag_rd.tag, idx, 4'h0}, data: data_rd, rw: 1'b1, valid: 1'b1};
               state_d   = WRITE_BACK;
            end else begin
               mem_req_d = alloc_req;
               state_d   = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            if (bus.mem_data.ready) begin
               mem_req_d = alloc_req;
               state_d   = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (bus.mem_data.ready) begin
               data_wr         = bus.mem_data.data;
               data_req.we     = 1'b1;
               tag_wr          = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
               tag_req.we      = 1'b1;
               mem_req_d.valid = 1'b0;
               state_d         = COMPARE_TAG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cpu_res = cpu_res;
   assign bus.mem_req = mem_req_q;

endmodule
